// File: rtl/field_select_pipe_pkg.sv
// Shared helpers for the packed-field extractor family.
// Holds the layout legality check so sibling extractors apply the same rule.
package field_select_pipe_pkg;

  // A layout is legal when every field fits in the word and the output can hold a field.
  function automatic bit field_layout_ok(input int sel_w, input int field_w,
                                         input int data_w, input int out_w);
    return (sel_w > 0) && (field_w > 0) &&
           (data_w >= sel_w + (2 ** sel_w) * field_w) &&
           (out_w >= field_w);
  endfunction

endpackage

// File: rtl/field_select_pipe_if.sv
// Upstream word channel and downstream result channel of field_select_pipe.
// The master side is the environment: it drives words and the downstream ready.
interface field_select_pipe_if #(
  parameter int DATA_W = 16,
  parameter int SEL_W  = 2,
  parameter int OUT_W  = 8
);
  logic [DATA_W-1:0] i_data;
  logic              i_sext;
  logic              i_valid;
  logic              o_ready;
  logic [OUT_W-1:0]  o_data;
  logic [SEL_W-1:0]  o_sel;
  logic              o_valid;
  logic              i_ready;

  modport master (
    output i_data, i_sext, i_valid, i_ready,
    input  o_ready, o_data, o_sel, o_valid
  );

  modport slave (
    input  i_data, i_sext, i_valid, i_ready,
    output o_ready, o_data, o_sel, o_valid
  );
endinterface

// File: rtl/field_select_pipe_field_extract.sv
// Combinational field picker: selector in the low bits chooses one packed field,
// which is then zero- or sign-extended to OUT_W.
module field_extract
  import field_select_pipe_pkg::*;
#(
  parameter int SEL_W   = 2,
  parameter int FIELD_W = 3,
  parameter int DATA_W  = 16,
  parameter int OUT_W   = 8
) (
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_sext,
  output logic [OUT_W-1:0]  o_field,
  output logic [SEL_W-1:0]  o_sel
);
  localparam int NUM_FIELDS = 2 ** SEL_W;
  localparam int TOP        = SEL_W + NUM_FIELDS * FIELD_W;

  if (!field_layout_ok(SEL_W, FIELD_W, DATA_W, OUT_W)) begin : g_bad_layout
    $error("field_extract: illegal layout SEL_W=%0d FIELD_W=%0d DATA_W=%0d OUT_W=%0d",
           SEL_W, FIELD_W, DATA_W, OUT_W);
  end

  logic [NUM_FIELDS-1:0][FIELD_W-1:0] fields;
  logic [FIELD_W-1:0]                 fld;

  for (genvar k = 0; k < NUM_FIELDS; k++) begin : g_field
    assign fields[k] = i_data[SEL_W + k*FIELD_W +: FIELD_W];
  end

  // Every selector value addresses a real field, so no out-of-range handling.
  assign o_sel = i_data[SEL_W-1:0];
  assign fld   = fields[o_sel];

  if (OUT_W > FIELD_W) begin : g_ext
    assign o_field = {{(OUT_W-FIELD_W){i_sext & fld[FIELD_W-1]}}, fld};
  end else begin : g_noext
    logic unused_sext;
    assign o_field     = fld;
    assign unused_sext = i_sext;
  end

  // Bits above the last field carry no meaning.
  if (DATA_W > TOP) begin : g_pad
    logic unused_pad;
    assign unused_pad = ^i_data[DATA_W-1:TOP];
  end
endmodule

// File: rtl/field_select_pipe.sv
// Flow-controlled field extractor: registered valid/ready output with a
// one-entry skid so o_ready comes from state only, never from i_ready.
module field_select_pipe
  import field_select_pipe_pkg::*;
#(
  parameter int SEL_W   = 2,
  parameter int FIELD_W = 3,
  parameter int DATA_W  = 16,
  parameter int OUT_W   = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  field_select_pipe_if.slave   bus
);
  logic [OUT_W-1:0] ext_field;
  logic [SEL_W-1:0] ext_sel;

  field_extract #(
    .SEL_W  (SEL_W),
    .FIELD_W(FIELD_W),
    .DATA_W (DATA_W),
    .OUT_W  (OUT_W)
  ) u_extract (
    .i_data (bus.i_data),
    .i_sext (bus.i_sext),
    .o_field(ext_field),
    .o_sel  (ext_sel)
  );

  logic [OUT_W-1:0] main_data_q, main_data_d, skid_data_q, skid_data_d;
  logic [SEL_W-1:0] main_sel_q,  main_sel_d,  skid_sel_q,  skid_sel_d;
  logic             main_vld_q,  main_vld_d,  skid_vld_q,  skid_vld_d;
  logic             in_fire, out_fire;

  assign bus.o_ready = !skid_vld_q && !i_rst;
  assign bus.o_data  = main_data_q;
  assign bus.o_sel   = main_sel_q;
  assign bus.o_valid = main_vld_q;

  assign in_fire  = bus.i_valid && bus.o_ready;
  assign out_fire = main_vld_q && bus.i_ready;

  always_comb begin
    main_data_d = main_data_q;
    main_sel_d  = main_sel_q;
    main_vld_d  = main_vld_q;
    skid_data_d = skid_data_q;
    skid_sel_d  = skid_sel_q;
    skid_vld_d  = skid_vld_q;
    if (!main_vld_q || out_fire) begin
      if (skid_vld_q) begin
        // o_ready is low whenever skid is full, so no new word competes here.
        main_data_d = skid_data_q;
        main_sel_d  = skid_sel_q;
        main_vld_d  = 1'b1;
        skid_vld_d  = 1'b0;
      end else begin
        main_vld_d = in_fire;
        if (in_fire) begin
          main_data_d = ext_field;
          main_sel_d  = ext_sel;
        end
      end
    end else if (in_fire) begin
      skid_data_d = ext_field;
      skid_sel_d  = ext_sel;
      skid_vld_d  = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      main_data_q <= '0;
      main_sel_q  <= '0;
      main_vld_q  <= 1'b0;
      skid_data_q <= '0;
      skid_sel_q  <= '0;
      skid_vld_q  <= 1'b0;
    end else begin
      main_data_q <= main_data_d;
      main_sel_q  <= main_sel_d;
      main_vld_q  <= main_vld_d;
      skid_data_q <= skid_data_d;
      skid_sel_q  <= skid_sel_d;
      skid_vld_q  <= skid_vld_d;
    end
  end
endmodule

// File: tb/tb_field_select_pipe.sv
// Directed bench for field_select_pipe: scoreboard of expected {sel,data} plus
// direct checks of latency, stall stability, reset and a wide-field variant.
module tb_field_select_pipe;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_assert = 0;
  int   n_fail   = 0;
  logic [9:0] sb[$];

  always #5 clk = ~clk;

  field_select_pipe_if #(.DATA_W(16), .SEL_W(2), .OUT_W(8)) bus_a ();
  field_select_pipe_if #(.DATA_W(35), .SEL_W(3), .OUT_W(4)) bus_b ();

  field_select_pipe #(.SEL_W(2), .FIELD_W(3), .DATA_W(16), .OUT_W(8)) dut_a (
    .i_clk(clk), .i_rst(rst), .bus(bus_a.slave));
  field_select_pipe #(.SEL_W(3), .FIELD_W(4), .DATA_W(35), .OUT_W(4)) dut_b (
    .i_clk(clk), .i_rst(rst), .bus(bus_b.slave));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference extraction for the default layout, written from the bit map.
  function automatic logic [9:0] model(input logic [15:0] d, input logic sx);
    logic [1:0] s;
    logic [2:0] f;
    logic [7:0] e;
    s = d[1:0];
    f = d[2 + 3*s +: 3];
    e = sx ? {{5{f[2]}}, f} : {5'b0, f};
    return {s, e};
  endfunction

  function automatic logic [15:0] pack(input logic [1:0] s, input int base);
    logic [15:0] d;
    d = {14'b0, s};
    for (int k = 0; k < 4; k++) d[2 + 3*k +: 3] = 3'((base + k) % 8);
    return d;
  endfunction

  // Scoreboard: push on in_fire, pop and compare on out_fire.
  always @(negedge clk) begin
    #2;
    if (rst) sb.delete();
    else begin
      if (bus_a.i_valid && bus_a.o_ready) sb.push_back(model(bus_a.i_data, bus_a.i_sext));
      if (bus_a.o_valid && bus_a.i_ready) begin
        if (sb.size() == 0) begin
          n_assert++;
          n_fail++;
          $error("FAIL sb_unexpected: observed %0h expected no output", {bus_a.o_sel, bus_a.o_data});
        end else chk("sb_out", {bus_a.o_sel, bus_a.o_data}, sb.pop_front());
      end
    end
  end

  task automatic send(input logic [15:0] d, input logic sx);
    bus_a.i_data  = d;
    bus_a.i_sext  = sx;
    bus_a.i_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      #1;
      if (bus_a.o_ready) begin
        @(negedge clk);
        bus_a.i_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    n_assert++;
    n_fail++;
    $error("FAIL send_timeout: observed o_ready low expected accept within 50 cycles");
    bus_a.i_valid = 1'b0;
  endtask

  logic [15:0] w0, w1, w2;
  logic [34:0] d35;

  initial begin
    bus_a.i_data = '0; bus_a.i_sext = 1'b0; bus_a.i_valid = 1'b0; bus_a.i_ready = 1'b1;
    bus_b.i_data = '0; bus_b.i_sext = 1'b0; bus_b.i_valid = 1'b0; bus_b.i_ready = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_o_ready", bus_a.o_ready, 0);
    chk("rst_o_valid", bus_a.o_valid, 0);
    chk("rst_o_data",  bus_a.o_data, 0);
    chk("rst_o_sel",   bus_a.o_sel, 0);
    rst = 1'b0;

    // Basic zero-extend with 1-cycle latency
    @(negedge clk);
    bus_a.i_data = 16'h3B2C; bus_a.i_sext = 1'b0; bus_a.i_valid = 1'b1;
    #1 chk("lat_pre_valid", bus_a.o_valid, 0);
    @(negedge clk);
    bus_a.i_valid = 1'b0;
    #1;
    chk("lat_valid", bus_a.o_valid, 1);
    chk("basic_data", bus_a.o_data, 8'h03);
    chk("basic_sel", bus_a.o_sel, 0);
    @(negedge clk);
    #1 chk("basic_drop", bus_a.o_valid, 0);

    // Sign vs zero extension of an all-ones field
    @(negedge clk);
    send(16'h001C, 1'b1);
    #1 chk("sext_ff", bus_a.o_data, 8'hFF);
    @(negedge clk);
    send(16'h001C, 1'b0);
    #1 chk("zext_07", bus_a.o_data, 8'h07);

    // Selector sweep, back-to-back
    @(negedge clk);
    for (int s = 0; s < 4; s++) begin
      send(pack(2'(s), 4), 1'b0);
      #1 chk("sweep_data", bus_a.o_data, 8'(4 + s));
      chk("sweep_sel", bus_a.o_sel, s);
      @(negedge clk);
    end

    // Backpressure: main holds w0, skid takes w1, w2 waits upstream
    w0 = pack(2'd1, 1); w1 = pack(2'd2, 2); w2 = pack(2'd3, 3);
    bus_a.i_ready = 1'b0;
    bus_a.i_data = w0; bus_a.i_sext = 1'b0; bus_a.i_valid = 1'b1;
    #1 chk("bp_ready0", bus_a.o_ready, 1);
    @(negedge clk);
    bus_a.i_data = w1;
    #1 chk("bp_ready1", bus_a.o_ready, 1);
    chk("bp_main_w0", {bus_a.o_sel, bus_a.o_data}, model(w0, 1'b0));
    @(negedge clk);
    bus_a.i_data = w2;
    #1 chk("bp_ready_low", bus_a.o_ready, 0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      #1 chk("bp_hold_ready", bus_a.o_ready, 0);
      chk("bp_hold_valid", bus_a.o_valid, 1);
      chk("bp_hold_data", {bus_a.o_sel, bus_a.o_data}, model(w0, 1'b0));
    end
    @(negedge clk);
    bus_a.i_ready = 1'b1;
    @(negedge clk);
    #1 chk("bp_drain_ready", bus_a.o_ready, 1);
    chk("bp_drain_w1", {bus_a.o_sel, bus_a.o_data}, model(w1, 1'b0));
    @(negedge clk);
    bus_a.i_valid = 1'b0;
    #1 chk("bp_drain_w2", {bus_a.o_sel, bus_a.o_data}, model(w2, 1'b0));
    @(negedge clk);
    #1 chk("bp_empty", bus_a.o_valid, 0);

    // Reset with main and skid full
    @(negedge clk);
    bus_a.i_ready = 1'b0;
    bus_a.i_data = pack(2'd0, 5); bus_a.i_valid = 1'b1;
    @(negedge clk);
    bus_a.i_data = pack(2'd3, 6);
    @(negedge clk);
    bus_a.i_valid = 1'b0;
    #1 chk("mr_full", bus_a.o_ready, 0);
    rst = 1'b1;
    #1 chk("mr_ready_in_rst", bus_a.o_ready, 0);
    @(negedge clk);
    #1;
    chk("mr_valid", bus_a.o_valid, 0);
    chk("mr_data", bus_a.o_data, 0);
    chk("mr_sel", bus_a.o_sel, 0);
    chk("mr_ready_rst", bus_a.o_ready, 0);
    rst = 1'b0;
    bus_a.i_ready = 1'b1;
    #1 chk("mr_ready_after", bus_a.o_ready, 1);
    @(negedge clk);
    #1 chk("mr_no_output", bus_a.o_valid, 0);
    send(pack(2'd2, 1), 1'b1);
    #1 chk("mr_first_valid", bus_a.o_valid, 1);
    chk("mr_first_data", {bus_a.o_sel, bus_a.o_data}, model(pack(2'd2, 1), 1'b1));

    // Wide-field variant: OUT_W == FIELD_W, no extension even with i_sext
    d35 = 35'({$urandom, $urandom});
    d35[2:0] = 3'd7;
    d35[34] = 1'b1;
    bus_b.i_data = d35; bus_b.i_sext = 1'b1; bus_b.i_valid = 1'b1;
    @(negedge clk);
    bus_b.i_valid = 1'b0;
    #1;
    chk("var_valid", bus_b.o_valid, 1);
    chk("var_data", bus_b.o_data, d35[34:31]);
    chk("var_sel", bus_b.o_sel, 7);

    repeat (3) @(negedge clk);
    #3 chk("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/field_select_pipe.md
Name: field_select_pipe

Overview:
Parametrised, flow-controlled field extractor. Each input word carries a selector in its low SEL_W bits, followed by NUM_FIELDS = 2**SEL_W packed fields of FIELD_W bits each. The block picks the addressed field and zero- or sign-extends it to OUT_W. It delivers the result through a registered valid/ready output with a one-entry skid buffer. It sits between an instruction/operand source and downstream consumers that may stall.

Parameters:
SEL_W, 2, selector width; NUM_FIELDS = 2**SEL_W (derived localparam)
FIELD_W, 3, width of each packed field
DATA_W, 16, input word width; must be >= SEL_W + NUM_FIELDS*FIELD_W (elaboration-time check)
OUT_W, 8, output width; must be >= FIELD_W (elaboration-time check)

Ports:
i_clk  in  1  clock; all state updates on posedge
i_rst  in  1  reset, synchronous, active-high
i_data  in  DATA_W  [SEL_W-1:0] selector; field k = i_data[SEL_W+k*FIELD_W +: FIELD_W]; bits above the last field ignored
i_sext  in  1  1 = sign-extend selected field, 0 = zero-extend; sampled with i_data
i_valid  in  1  upstream word valid
o_ready  out  1  block can accept a word this cycle
o_data  out  OUT_W  extended field
o_sel  out  SEL_W  selector that produced o_data
o_valid  out  1  o_data/o_sel valid
i_ready  in  1  downstream accepts when o_valid && i_ready

Behaviour:
- Reset (i_rst=1 at posedge): o_data=0, o_sel=0, o_valid=0, skid cleared. o_ready=0 while i_rst is high; inputs ignored.
- Extraction: purely combinational on i_data. Selector s picks field s; all 2**SEL_W selector values are valid (no out-of-range case). Extension: upper OUT_W-FIELD_W bits are 0 (i_sext=0) or copies of field MSB (i_sext=1). If OUT_W==FIELD_W, no extension.
- Handshakes: in_fire = i_valid && o_ready; out_fire = o_valid && i_ready. Data may change only on fire; o_data/o_sel/o_valid are stable while o_valid && !i_ready.
- o_ready = !skid_valid && !i_rst. It is registered-state derived and does not depend on i_ready combinationally.
- Main register update per cycle:
  - Main empty or out_fire, skid empty: an in_fire word loads main. If there is no in_fire, o_valid drops to 0 after out_fire.
  - Main empty or out_fire, skid full: skid moves to main. Skid is cleared. No in_fire is possible, because o_ready=0.
  - Main full, no out_fire: an in_fire word loads skid, and o_ready goes low next cycle.
- Latency: 1 cycle, from in_fire at edge N to o_valid with that word after edge N.
- Throughput: 1 word/cycle sustained with i_ready held high. Order is strictly preserved; no drops or duplicates.
- Simultaneous in_fire and out_fire with skid empty: new word replaces main, and o_valid stays 1.
- Reset mid-transfer: main and skid contents discarded; no output after reset until a new in_fire.

Decomposition:
- Shared package: no typedefs required. Width-check macro/function (field_layout_ok) in the team package for reuse by sibling extractors.
- Sub-module: field_extract. Combinational, parameters SEL_W/FIELD_W/DATA_W/OUT_W; inputs i_data and i_sext; outputs extended field and selector. Instantiated once ahead of the output/skid registers.

Test Plan:
- Default params, i_ready=1, zero-extend: i_data=16'h3B2C, sel=0 → o_data=8'h03, o_sel=0, o_valid exactly 1 cycle after in_fire.
- Default params, sign-extend: i_data=16'h001C (sel=0, field0=3'b111), i_sext=1 → o_data=8'hFF; same word with i_sext=0 → 8'h07.
- Sweep all 4 selectors with field k = k+4 packed, zero-extend → outputs 8'h04, 8'h05, 8'h06, 8'h07 in order on back-to-back cycles.
- Backpressure: send 3 words, i_ready=0 → main holds word0 stable, skid takes word1, o_ready=0 from the next cycle, word2 held upstream. Then raise i_ready → word0, word1, word2 delivered in order with no loss.
- Reset mid-stream: main and skid full, assert i_rst for 1 cycle → o_valid=0, o_data=0, o_sel=0. o_ready=0 during reset and 1 the cycle after; first post-reset word appears with 1-cycle latency.
- Parameter variant SEL_W=3, FIELD_W=4, DATA_W=35, OUT_W=4: sel=7 → o_data equals i_data[34:31], with no extension applied.
